// File: rtl/alu_pkg.sv
// Shared opcode set and rotate helpers for the pipelined ALU (alu_pipe).
// Optional sticky-overflow feature is selected by ALU_PIPE_STICKY_OVF_EN in alu_pipe.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ROL = 4'd0,
    OP_ROR = 4'd1,
    OP_MAX = 4'd2,
    OP_MIN = 4'd3,
    OP_NOR = 4'd4,
    OP_SEQ = 4'd5,
    OP_ADD = 4'd6,
    OP_SRL = 4'd7,
    OP_SUB = 4'd8
  } op_e;

  localparam int OP_COUNT = 9;

  // Widest datapath the rotate helpers support; callers pass their real width in w.
  localparam int MAX_W   = 1024;
  localparam int MAX_SHW = $clog2(MAX_W);

  // Rotate left within the low w bits: bit i takes source bit (i - sh) mod w.
  function automatic logic [MAX_W-1:0] rol(input logic [MAX_W-1:0] a,
                                           input logic [MAX_SHW-1:0] sh,
                                           input logic [MAX_SHW:0] w);
    logic [MAX_W-1:0] r;
    logic [MAX_SHW:0] idx;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < int'(w)) begin
        idx = (MAX_SHW+1)'(i) + w - {1'b0, sh};
        if (idx >= w) idx = idx - w;
        r[i] = a[idx[MAX_SHW-1:0]];
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] ror(input logic [MAX_W-1:0] a,
                                           input logic [MAX_SHW-1:0] sh,
                                           input logic [MAX_SHW:0] w);
    logic [MAX_W-1:0] r;
    logic [MAX_SHW:0] idx;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < int'(w)) begin
        idx = (MAX_SHW+1)'(i) + {1'b0, sh};
        if (idx >= w) idx = idx - w;
        r[i] = a[idx[MAX_SHW-1:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational op/flag evaluation for alu_pipe; sits between stage 1 and the stage 2 registers.
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shiftValue,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  localparam logic [MAX_SHW:0] W_ARG = (MAX_SHW+1)'(WIDTH);

  always_comb begin
    // NOTE: every output gets a default first, so no opcode path can infer a latch.
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (opcode)
      OP_ROL: result = WIDTH'(rol(MAX_W'(input1), MAX_SHW'(shiftValue), W_ARG));
      OP_ROR: result = WIDTH'(ror(MAX_W'(input1), MAX_SHW'(shiftValue), W_ARG));
      OP_MAX: result = (input1 >= input2) ? input1 : input2;
      OP_MIN: result = (input1 <= input2) ? input1 : input2;
      OP_NOR: result = ~(input1 | input2);
      OP_SEQ: result = WIDTH'(input1 == input2);
      OP_ADD: begin
        {carry, result} = {1'b0, input1} + {1'b0, input2};
        ovf = (input1[WIDTH-1] == input2[WIDTH-1]) && (result[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_SRL: result = input1 >> shiftValue;
      OP_SUB: begin
        result = input1 - input2;
        carry  = input1 < input2;
        ovf    = (input1[WIDTH-1] != input2[WIDTH-1]) && (result[WIDTH-1] != input1[WIDTH-1]);
      end
      default: ;  // unassigned opcodes yield result 0, flags clear
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: stage 1 holds operands, stage 2 holds result and flags.
// Define ALU_PIPE_STICKY_OVF_EN to add the ovfSticky output and ovfClear input.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shiftValue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             overFlowFlag
`ifdef ALU_PIPE_STICKY_OVF_EN
  ,
  input  logic             ovfClear,
  output logic             ovfSticky
`endif
);

  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [SHW-1:0]   s1_sh;

  logic             s1_load, s2_load;
  logic [WIDTH-1:0] core_result;
  logic             core_carry, core_zero, core_ovf;

  // Each stage advances when it is empty or its successor takes its beat this cycle.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so each stage samples the other's pre-edge value.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sh    <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= opcode;
        s1_a  <= input1;
        s1_b  <= input2;
        s1_sh <= shiftValue;
      end
    end
  end

  alu_pipe_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .opcode    (s1_op),
    .input1    (s1_a),
    .input2    (s1_b),
    .shiftValue(s1_sh),
    .result    (core_result),
    .carry     (core_carry),
    .zero      (core_zero),
    .ovf       (core_ovf)
  );

  // Result/flags only change when a real beat lands, so a stalled output stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      result       <= '0;
      carryFlag    <= 1'b0;
      zeroFlag     <= 1'b0;
      overFlowFlag <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result       <= core_result;
        carryFlag    <= core_carry;
        zeroFlag     <= core_zero;
        overFlowFlag <= core_ovf;
      end
    end
  end

`ifdef ALU_PIPE_STICKY_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          ovfSticky <= 1'b0;
    else if (ovfClear)                                   ovfSticky <= 1'b0;
    else if (out_valid && out_ready && overFlowFlag)     ovfSticky <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner ops, random flow-controlled traffic, reset abort.
// Also exercises ovfSticky/ovfClear when ALU_PIPE_STICKY_OVF_EN is defined.
module tb_alu_pipe;

  localparam int W  = 128;
  localparam int SW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    opcode;
  logic [W-1:0]  input1, input2, result;
  logic [SW-1:0] shiftValue;
  logic          carryFlag, zeroFlag, overFlowFlag;
`ifdef ALU_PIPE_STICKY_OVF_EN
  logic          ovfClear, ovfSticky;
`endif

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .input1      (input1),
    .input2      (input2),
    .shiftValue  (shiftValue),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .carryFlag   (carryFlag),
    .zeroFlag    (zeroFlag),
    .overFlowFlag(overFlowFlag)
`ifdef ALU_PIPE_STICKY_OVF_EN
    ,
    .ovfClear    (ovfClear),
    .ovfSticky   (ovfSticky)
`endif
  );

  typedef struct {
    logic [W-1:0] r;
    logic         c, z, o;
  } exp_t;

  int           n_checks = 0;
  int           n_errors = 0;
  exp_t         q[$];
  logic         stalled_prev = 1'b0;
  logic [W-1:0] held_r = '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic z, input logic o);
    exp_t e;
    e.r = r; e.c = c; e.z = z; e.o = o;
    return e;
  endfunction

  // Reference: plain arithmetic on the operand values, signed overflow via a W+1-bit signed result.
  function automatic exp_t ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [SW-1:0] sh);
    exp_t               e;
    logic [W:0]         s;
    logic signed [W:0]  sg;
    int                 k;
    e = mk('0, 1'b0, 1'b0, 1'b0);
    k = int'(sh);
    case (op)
      4'd0: e.r = (k == 0) ? a : ((a << k) | (a >> (W - k)));
      4'd1: e.r = (k == 0) ? a : ((a >> k) | (a << (W - k)));
      4'd2: e.r = (a >= b) ? a : b;
      4'd3: e.r = (a <= b) ? a : b;
      4'd4: e.r = ~(a | b);
      4'd5: e.r = (a == b) ? W'(1) : '0;
      4'd6: begin
        s   = {1'b0, a} + {1'b0, b};
        e.r = s[W-1:0];
        e.c = s[W];
        sg  = $signed({a[W-1], a}) + $signed({b[W-1], b});
        e.o = sg[W] != sg[W-1];
      end
      4'd7: e.r = a >> k;
      4'd8: begin
        e.r = a - b;
        e.c = a < b;
        sg  = $signed({a[W-1], a}) - $signed({b[W-1], b});
        e.o = sg[W] != sg[W-1];
      end
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // One cycle of traffic, entered and left 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [SW-1:0] sh, input logic ordy);
    logic acc, dlv;
    in_valid = v; opcode = op; input1 = a; input2 = b; shiftValue = sh; out_ready = ordy;
    @(negedge clk);
    check("in_ready", W'(in_ready), W'(!(q.size() == 2 && !ordy)));
    if (q.size() == 2) check("out_valid_full", W'(out_valid), W'(1'b1));
    if (q.size() == 0) check("out_valid_empty", W'(out_valid), '0);
    if (stalled_prev) begin
      check("stall_valid", W'(out_valid), W'(1'b1));
      check("stall_result", result, held_r);
    end
    if (out_valid && q.size() > 0) begin
      check("result", result, q[0].r);
      check("carry", W'(carryFlag), W'(q[0].c));
      check("zero", W'(zeroFlag), W'(q[0].z));
      check("ovf", W'(overFlowFlag), W'(q[0].o));
    end
    acc = v && in_ready;
    dlv = out_valid && ordy;
    stalled_prev = out_valid && !ordy;
    held_r = result;
    if (dlv && q.size() > 0) q.delete(0);
    if (acc) q.push_back(ref_alu(op, a, b, sh));
    @(posedge clk); #1;
  endtask

  // Single beat through an empty pipe with out_ready=1: checks exact 2-cycle latency and fixed values.
  task automatic directed(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [SW-1:0] sh, input exp_t e);
    in_valid = 1'b1; opcode = op; input1 = a; input2 = b; shiftValue = sh; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, W'(in_ready), W'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early_valid"}, W'(out_valid), '0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_valid"}, W'(out_valid), W'(1'b1));
    check({tag, "_result"}, result, e.r);
    check({tag, "_carry"}, W'(carryFlag), W'(e.c));
    check({tag, "_zero"}, W'(zeroFlag), W'(e.z));
    check({tag, "_ovf"}, W'(overFlowFlag), W'(e.o));
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [W-1:0] ones, msb1, max_pos, c81, a, b;
    logic         v, ordy;
    ones    = '1;
    msb1    = {1'b1, {(W-1){1'b0}}};
    max_pos = ones >> 1;
    c81     = msb1 | W'(1);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opcode = '0;
    input1 = '0; input2 = '0; shiftValue = '0;
`ifdef ALU_PIPE_STICKY_OVF_EN
    ovfClear = 1'b0;
`endif
    #12;
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_result", result, '0);
    check("rst_flags", W'({carryFlag, zeroFlag, overFlowFlag}), '0);
    check("rst_in_ready", W'(in_ready), W'(1'b1));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    directed("add_wrap", 4'd6, ones, W'(1), '0, mk('0, 1'b1, 1'b1, 1'b0));
    directed("add_ovf", 4'd6, max_pos, W'(1), '0, mk(msb1, 1'b0, 1'b0, 1'b1));
    directed("sub_borrow", 4'd8, W'(3), W'(5), '0, mk(ones - W'(1), 1'b1, 1'b0, 1'b0));
    directed("rol0", 4'd0, c81, '0, '0, mk(c81, 1'b0, 1'b0, 1'b0));
    directed("ror0", 4'd1, c81, '0, '0, mk(c81, 1'b0, 1'b0, 1'b0));
    directed("rol1", 4'd0, c81, '0, SW'(1), mk(W'(3), 1'b0, 1'b0, 1'b0));
    directed("ror1", 4'd1, c81, '0, SW'(1), mk(msb1 | (msb1 >> 1), 1'b0, 1'b0, 1'b0));
    directed("seq_eq", 4'd5, W'(5), W'(5), '0, mk(W'(1), 1'b0, 1'b0, 1'b0));
    directed("op12", 4'd12, ones, ones, '0, mk('0, 1'b0, 1'b1, 1'b0));
    directed("min", 4'd3, W'(7), W'(9), '0, mk(W'(7), 1'b0, 1'b0, 1'b0));
    directed("srl", 4'd7, ones, '0, SW'(W - 1), mk(W'(1), 1'b0, 1'b0, 1'b0));

    // Random back-to-back traffic with a randomly throttled consumer.
    stalled_prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      v    = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 1) != 0;
      a    = ($urandom_range(0, 7) == 0) ? ones : rnd_word();
      b    = ($urandom_range(0, 3) == 0) ? a : rnd_word();
      step(v, 4'($urandom_range(0, 15)), a, b, SW'($urandom), ordy);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) step(1'b0, '0, '0, '0, '0, 1'b1);
    check("drain_empty", W'(q.size()), '0);
    step(1'b0, '0, '0, '0, '0, 1'b1);

    // Two beats in flight, then an asynchronous reset between edges.
    step(1'b1, 4'd6, W'(10), W'(20), '0, 1'b0);
    step(1'b1, 4'd6, W'(30), W'(40), '0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", W'(out_valid), '0);
    check("abort_in_ready", W'(in_ready), W'(1'b1));
    q.delete();
    stalled_prev = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, '0, 1'b1);

`ifdef ALU_PIPE_STICKY_OVF_EN
    check("sticky_rst", W'(ovfSticky), '0);
    directed("st_ovf", 4'd6, max_pos, W'(1), '0, mk(msb1, 1'b0, 1'b0, 1'b1));
    check("sticky_set", W'(ovfSticky), W'(1'b1));
    directed("st_clean", 4'd6, W'(1), W'(1), '0, mk(W'(2), 1'b0, 1'b0, 1'b0));
    check("sticky_hold", W'(ovfSticky), W'(1'b1));
    ovfClear = 1'b1;
    @(posedge clk); #1;
    ovfClear = 1'b0;
    check("sticky_clear", W'(ovfSticky), '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
